// File: rtl/stripe_frame_ctrl_if.sv
// Byte-stream input handshake and lane-word output bundle for stripe_frame_ctrl.
// master: upstream byte source / observer; slave: the frame controller.
interface stripe_frame_ctrl_if #(
  parameter int unsigned numlanes = 4
);
  logic [7:0]            s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [numlanes*8-1:0] stripe_data;
  logic [numlanes-1:0]   stripe_k;
  logic                  stripe_dvalid;
  logic                  busy;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, stripe_data, stripe_k, stripe_dvalid, busy
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, stripe_data, stripe_k, stripe_dvalid, busy
  );
endinterface

// File: rtl/stripe_frame_ctrl.sv
// Frame scheduler ahead of the byte-striping stage: gathers numlanes bytes per
// lane word, brackets each packet with SOF/EOF control words, pads a partial
// last word with K23.7 and fills every other cycle with K28.5 idles.
// Optional macro STRIPE_SKIP_EN inserts a K28.0 SKIP word every SKIP_INTERVAL
// output words, only while the link is idle between frames.
module stripe_frame_ctrl #(
  parameter int unsigned numlanes      = 4,
  parameter int unsigned SKIP_INTERVAL = 1024
) (
  input logic              clk_1G,
  input logic              rst_1G,
  stripe_frame_ctrl_if.slave bus
);

  localparam int unsigned W    = numlanes * 8;
  localparam int unsigned CntW = (numlanes > 1) ? $clog2(numlanes) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(numlanes - 1);

  localparam logic [W-1:0] IdleWord = {numlanes{8'hBC}};
  localparam logic [W-1:0] SofWord  = {8'hFB, {(numlanes - 1){8'hBC}}};
  localparam logic [W-1:0] EofWord  = {8'hFD, {(numlanes - 1){8'hBC}}};

  typedef enum logic [1:0] {StIdle, StSof, StFill, StEof} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            eof_pending;
  logic [7:0]      stage [numlanes];

  logic            xfer;
  logic            complete;
  logic [W-1:0]    merged_data;
  logic [numlanes-1:0] merged_k;
  logic            skip_take;

  assign xfer     = bus.s_valid & bus.s_ready & (state == StFill);
  assign complete = xfer & (bus.s_last | (cnt == LastCnt));

  // Merge staged bytes, the incoming byte and PAD fill into one lane word.
  always_comb begin
    merged_data = '0;
    merged_k    = '0;
    for (int i = 0; i < int'(numlanes); i++) begin
      if (i < int'(cnt)) begin
        merged_data[(numlanes - i) * 8 - 1 -: 8] = stage[i];
        merged_k[numlanes - 1 - i]               = 1'b0;
      end else if (i == int'(cnt)) begin
        merged_data[(numlanes - i) * 8 - 1 -: 8] = bus.s_data;
        merged_k[numlanes - 1 - i]               = 1'b0;
      end else begin
        merged_data[(numlanes - i) * 8 - 1 -: 8] = 8'hF7;
        merged_k[numlanes - 1 - i]               = 1'b1;
      end
    end
  end

`ifdef STRIPE_SKIP_EN
  localparam int unsigned SkipW = (SKIP_INTERVAL > 2) ? $clog2(SKIP_INTERVAL) : 1;
  localparam logic [W-1:0] SkipWord = {numlanes{8'h1C}};

  logic [SkipW-1:0] skip_cnt;
  logic             skip_pending;

  assign skip_take = skip_pending & (state == StIdle);

  // Word counter: pending is raised on the step that reaches SKIP_INTERVAL-1,
  // so an idle link sees exactly one SKIP every SKIP_INTERVAL words.
  always_ff @(posedge clk_1G or negedge rst_1G) begin
    if (!rst_1G) begin
      skip_cnt     <= '0;
      skip_pending <= 1'b0;
    end else if (skip_take) begin
      skip_cnt     <= '0;
      skip_pending <= 1'b0;
    end else if (!skip_pending) begin
      skip_cnt <= skip_cnt + 1'b1;
      if (skip_cnt == SkipW'(SKIP_INTERVAL - 2)) begin
        skip_pending <= 1'b1;
      end
    end
  end
`else
  assign skip_take = 1'b0;
`endif

  // Frame FSM with registered outputs; state names the word currently on the
  // output, except that a data word is shown while still in StFill.
  always_ff @(posedge clk_1G or negedge rst_1G) begin
    if (!rst_1G) begin
      state             <= StIdle;
      cnt               <= '0;
      eof_pending       <= 1'b0;
      bus.s_ready       <= 1'b0;
      bus.busy          <= 1'b0;
      bus.stripe_data   <= IdleWord;
      bus.stripe_k      <= '1;
      bus.stripe_dvalid <= 1'b0;
      for (int i = 0; i < int'(numlanes); i++) begin
        stage[i] <= 8'h00;
      end
    end else begin
      bus.stripe_data   <= IdleWord;
      bus.stripe_k      <= '1;
      bus.stripe_dvalid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (skip_take) begin
`ifdef STRIPE_SKIP_EN
            bus.stripe_data <= SkipWord;
`endif
          end else if (bus.s_valid) begin
            state           <= StSof;
            bus.stripe_data <= SofWord;
            bus.busy        <= 1'b1;
          end
        end
        StSof: begin
          state       <= StFill;
          bus.s_ready <= 1'b1;
        end
        StFill: begin
          if (eof_pending) begin
            // Last data word has been shown; follow it with EOF.
            state           <= StEof;
            eof_pending     <= 1'b0;
            bus.stripe_data <= EofWord;
          end else if (complete) begin
            bus.stripe_data   <= merged_data;
            bus.stripe_k      <= merged_k;
            bus.stripe_dvalid <= 1'b1;
            cnt               <= '0;
            if (bus.s_last) begin
              bus.s_ready <= 1'b0;
              eof_pending <= 1'b1;
            end
          end else if (xfer) begin
            stage[cnt] <= bus.s_data;
            cnt        <= cnt + 1'b1;
          end
        end
        StEof: begin
          state    <= StIdle;
          bus.busy <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stripe_frame_ctrl.sv
// Directed bench for stripe_frame_ctrl with numlanes = 4.
module tb_stripe_frame_ctrl;

`ifdef STRIPE_SKIP_EN
  localparam int unsigned SkipIv = 8;
`else
  localparam int unsigned SkipIv = 1024;
`endif

  localparam logic [31:0] Idle = 32'hBCBCBCBC;
  localparam logic [31:0] Sof  = 32'hFBBCBCBC;
  localparam logic [31:0] Eof  = 32'hFDBCBCBC;

  logic clk_1G;
  logic rst_1G;

  stripe_frame_ctrl_if #(.numlanes(4)) bus ();

  stripe_frame_ctrl #(
    .numlanes     (4),
    .SKIP_INTERVAL(SkipIv)
  ) dut (
    .clk_1G(clk_1G),
    .rst_1G(rst_1G),
    .bus   (bus)
  );

  initial clk_1G = 1'b0;
  always #5 clk_1G = ~clk_1G;

  int n_cmp;
  int n_fail;

  // Frame stimulus and per-cycle output capture.
  logic [7:0]  fb [16];
  int          fn;
  bit          bubbles;
  logic [31:0] cd [32];
  logic [3:0]  ck [32];
  logic        cv [32];
  logic        cb [32];

  // Drive one frame byte by byte and capture outputs #1 after each edge.
  task automatic drive_frame(input int ncyc);
    int idx;
    bit x;
    idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < fn && (!bubbles || (c % 2) == 0)) begin
        bus.s_valid = 1'b1;
        bus.s_data  = fb[idx];
        bus.s_last  = (idx == fn - 1);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'hEE;
        bus.s_last  = 1'b1;
      end
      x = bus.s_valid && bus.s_ready;
      @(posedge clk_1G);
      #1;
      if (x) idx++;
      cd[c] = bus.stripe_data;
      ck[c] = bus.stripe_k;
      cv[c] = bus.stripe_dvalid;
      cb[c] = bus.busy;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst_1G      = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h55;
    bus.s_last  = 1'b0;
    repeat (3) @(posedge clk_1G);
    #1;
    n_cmp++;
    if (bus.stripe_data !== Idle) begin
      n_fail++;
      $display("FAIL reset data: got %h want %h", bus.stripe_data, Idle);
    end
    n_cmp++;
    if ({bus.stripe_k, bus.stripe_dvalid, bus.s_ready, bus.busy} !== 7'b1111_000) begin
      n_fail++;
      $display("FAIL reset k/dvalid/ready/busy: got %b want %b",
               {bus.stripe_k, bus.stripe_dvalid, bus.s_ready, bus.busy}, 7'b1111_000);
    end
    @(negedge clk_1G);
    rst_1G      = 1'b1;
    bus.s_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_1G);
      #1;
      n_cmp++;
      if ({bus.stripe_data, bus.busy, bus.s_ready} !== {Idle, 2'b00}) begin
        n_fail++;
        $display("FAIL post-reset idle cyc %0d: got %h/%b%b want %h/00",
                 c, bus.stripe_data, bus.busy, bus.s_ready, Idle);
      end
    end
  endtask

  task automatic test_frame8();
    logic [31:0] ed [16];
    logic [3:0]  ek [16];
    logic        ev [16];
    logic        eb [16];
    for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
    fn = 8;
    bubbles = 1'b0;
    drive_frame(13);
    for (int i = 0; i < 13; i++) begin
      ed[i] = Idle; ek[i] = 4'hF; ev[i] = 1'b0; eb[i] = 1'b1;
    end
    ed[0] = Sof;
    ed[5] = 32'h01020304; ek[5] = 4'h0; ev[5] = 1'b1;
    ed[9] = 32'h05060708; ek[9] = 4'h0; ev[9] = 1'b1;
    ed[10] = Eof;
    eb[11] = 1'b0; eb[12] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      n_cmp++;
      if (cd[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL frame8 data cyc %0d: got %h want %h", i, cd[i], ed[i]);
      end
      n_cmp++;
      if ({ck[i], cv[i], cb[i]} !== {ek[i], ev[i], eb[i]}) begin
        n_fail++;
        $display("FAIL frame8 k/dvalid/busy cyc %0d: got %b want %b",
                 i, {ck[i], cv[i], cb[i]}, {ek[i], ev[i], eb[i]});
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] ed [16];
    logic [3:0]  ek [16];
    logic        ev [16];
    logic        eb [16];
    for (int i = 0; i < 6; i++) fb[i] = 8'(8'h11 + i);
    fn = 6;
    bubbles = 1'b0;
    drive_frame(10);
    for (int i = 0; i < 10; i++) begin
      ed[i] = Idle; ek[i] = 4'hF; ev[i] = 1'b0; eb[i] = 1'b1;
    end
    ed[0] = Sof;
    ed[5] = 32'h11121314; ek[5] = 4'h0; ev[5] = 1'b1;
    ed[7] = 32'h1516F7F7; ek[7] = 4'h3; ev[7] = 1'b1;
    ed[8] = Eof;
    eb[9] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (cd[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL partial data cyc %0d: got %h want %h", i, cd[i], ed[i]);
      end
      n_cmp++;
      if ({ck[i], cv[i], cb[i]} !== {ek[i], ev[i], eb[i]}) begin
        n_fail++;
        $display("FAIL partial k/dvalid/busy cyc %0d: got %b want %b",
                 i, {ck[i], cv[i], cb[i]}, {ek[i], ev[i], eb[i]});
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] ed [8];
    logic [3:0]  ek [8];
    logic        ev [8];
    logic        eb [8];
    int          nbusy;
    fb[0] = 8'hA5;
    fn = 1;
    bubbles = 1'b0;
    drive_frame(6);
    for (int i = 0; i < 6; i++) begin
      ed[i] = Idle; ek[i] = 4'hF; ev[i] = 1'b0; eb[i] = 1'b0;
    end
    ed[0] = Sof; eb[0] = 1'b1;
    eb[1] = 1'b1;
    ed[2] = 32'hA5F7F7F7; ek[2] = 4'h7; ev[2] = 1'b1; eb[2] = 1'b1;
    ed[3] = Eof; eb[3] = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      if (cb[i] === 1'b1) nbusy++;
      n_cmp++;
      if ({cd[i], ck[i], cv[i], cb[i]} !== {ed[i], ek[i], ev[i], eb[i]}) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %h/%b%b%b want %h/%b%b%b",
                 i, cd[i], ck[i], cv[i], cb[i], ed[i], ek[i], ev[i], eb[i]);
      end
    end
    n_cmp++;
    if (nbusy != 4) begin
      n_fail++;
      $display("FAIL single busy count: got %0d want 4", nbusy);
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] ed [16];
    logic [3:0]  ek [16];
    logic        ev [16];
    logic        eb [16];
    int          nvalid;
    for (int i = 0; i < 4; i++) fb[i] = 8'(i + 1);
    fn = 4;
    bubbles = 1'b1;
    drive_frame(12);
    bubbles = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ed[i] = Idle; ek[i] = 4'hF; ev[i] = 1'b0; eb[i] = 1'b1;
    end
    ed[0] = Sof;
    ed[8] = 32'h01020304; ek[8] = 4'h0; ev[8] = 1'b1;
    ed[9] = Eof;
    eb[10] = 1'b0; eb[11] = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (cv[i] === 1'b1) nvalid++;
      n_cmp++;
      if ({cd[i], ck[i], cv[i], cb[i]} !== {ed[i], ek[i], ev[i], eb[i]}) begin
        n_fail++;
        $display("FAIL bubbles cyc %0d: got %h/%b%b%b want %h/%b%b%b",
                 i, cd[i], ck[i], cv[i], cb[i], ed[i], ek[i], ev[i], eb[i]);
      end
    end
    n_cmp++;
    if (nvalid != 1) begin
      n_fail++;
      $display("FAIL bubbles dvalid count: got %0d want 1", nvalid);
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] ed [8];
    for (int i = 0; i < 4; i++) fb[i] = 8'(i + 1);
    fn = 4;
    bubbles = 1'b0;
    drive_frame(4);
    // Bytes 01 and 02 have transferred; drop the frame with an async reset.
    #2;
    rst_1G = 1'b0;
    #1;
    n_cmp++;
    if ({bus.stripe_data, bus.stripe_k, bus.stripe_dvalid, bus.s_ready, bus.busy} !==
        {Idle, 4'hF, 3'b000}) begin
      n_fail++;
      $display("FAIL midreset immediate: got %h/%b%b%b%b want %h/1111000", bus.stripe_data,
               bus.stripe_k, bus.stripe_dvalid, bus.s_ready, bus.busy, Idle);
    end
    @(negedge clk_1G);
    rst_1G = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_1G);
      #1;
      n_cmp++;
      if ({bus.stripe_data, bus.busy} !== {Idle, 1'b0}) begin
        n_fail++;
        $display("FAIL midreset no-eof cyc %0d: got %h/%b want %h/0",
                 c, bus.stripe_data, bus.busy, Idle);
      end
    end
    for (int i = 0; i < 4; i++) fb[i] = 8'(8'h21 + i);
    drive_frame(8);
    for (int i = 0; i < 8; i++) ed[i] = Idle;
    ed[0] = Sof;
    ed[5] = 32'h21222324;
    ed[6] = Eof;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cd[i] !== ed[i]) begin
        n_fail++;
        $display("FAIL midreset refr data cyc %0d: got %h want %h", i, cd[i], ed[i]);
      end
    end
    n_cmp++;
    if ({cv[5], ck[5], cb[7]} !== {1'b1, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset refr flags: got %b want 100000", {cv[5], ck[5], cb[7]});
    end
  endtask

`ifdef STRIPE_SKIP_EN
  task automatic test_skip();
    int last;
    int nskip;
    last  = -1;
    nskip = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_1G);
      #1;
      if (bus.stripe_data === 32'h1C1C1C1C) begin
        n_cmp++;
        if (last >= 0 && (c - last) != 8) begin
          n_fail++;
          $display("FAIL skip spacing: got %0d want 8", c - last);
        end
        n_cmp++;
        if (bus.stripe_k !== 4'hF) begin
          n_fail++;
          $display("FAIL skip k: got %b want 1111", bus.stripe_k);
        end
        last = c;
        nskip++;
      end else begin
        n_cmp++;
        if (bus.stripe_data !== Idle) begin
          n_fail++;
          $display("FAIL skip idle cyc %0d: got %h want %h", c, bus.stripe_data, Idle);
        end
      end
    end
    n_cmp++;
    if (nskip < 4) begin
      n_fail++;
      $display("FAIL skip count: got %0d want >= 4", nskip);
    end
  endtask
`endif

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    fn      = 0;
    bubbles = 1'b0;
    test_reset();
`ifdef STRIPE_SKIP_EN
    test_skip();
`else
    test_frame8();
    test_partial();
    test_single();
    test_bubbles();
    test_midframe_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stripe_frame_ctrl.md
Name: stripe_frame_ctrl

Overview:
- Frame scheduler in front of the byte-striping register stage.
- Accepts a byte stream through a valid/ready handshake and gathers numlanes bytes per lane word.
- Frames each packet with SOF/EOF control words, pads a partial final word, and fills all other cycles with idle control characters.
- Its outputs feed the striping register stage and the per-lane 8b/10b encoders, which take the K flags.

Parameters:
- numlanes, 4, lane count; legal 2..8.
- SKIP_INTERVAL, 1024, output words between SKIP ordered sets (used only with STRIPE_SKIP_EN).

Ports:
- clk_1G  in  1  byte-lane clock.
- rst_1G  in  1  asynchronous active-low reset.
- s_data  in  8  input byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  final byte of frame; qualified by s_valid.
- s_ready  out  1  controller accepts a byte this cycle.
- stripe_data  out  numlanes*8  lane word; lane 0 = MSB byte [numlanes*8-1 -: 8], lane i = next lower byte.
- stripe_k  out  numlanes  per-lane K flag; bit numlanes-1-i belongs to lane i.
- stripe_dvalid  out  1  stripe_data carries frame payload.
- busy  out  1  high from SOF to EOF inclusive.

Behaviour:
- Constants:
  - IDLE = K28.5 0xBC; SOF = K27.7 0xFB; EOF = K29.7 0xFD; PAD = K23.7 0xF7; SKIP = K28.0 0x1C.
  - Idle word = all lanes 0xBC, all K=1.
- All outputs are registered and produce a word every cycle; there is no output backpressure.
- Reset (async, immediate):
  - stripe_data = idle word, stripe_k = all ones.
  - stripe_dvalid = 0, s_ready = 0, busy = 0.
  - Byte count = 0; state = IDLE.
- States:
  - IDLE: s_ready=0; emit idle word. If s_valid=1, go to SOF.
  - SOF: emit SOF word: lane 0 = 0xFB, other lanes 0xBC, all K=1, busy=1. Go to FILL; s_ready=1 from the next cycle.
  - FILL:
    - s_ready=1. A byte transfers on s_valid & s_ready.
    - Byte with count c goes to lane c of the staging buffer.
    - Idle word is emitted on each cycle no data word completes; busy stays 1.
    - Word completion: transfer with c = numlanes-1, or any transfer with s_last=1.
    - On completion, the merged word loads directly into the output registers at that edge: latency 1 clock from the final byte's edge. stripe_dvalid=1.
    - Lanes above c carry 0xF7 with K=1; payload lanes have K=0.
    - Count returns to 0.
    - Bubbles (s_valid=0) hold the count and emit idle.
  - EOF: entered after completion with s_last. s_ready=0. Emit EOF word: lane 0 = 0xFD, others 0xBC, all K=1, busy=1. Return to IDLE.
- IDLE therefore lasts at least 1 cycle between frames; s_valid held high is not accepted until FILL.
- Back-to-back frames, minimum cycle: SOF, FILL…, EOF, IDLE.
- s_last on the first byte gives a single word: 1 payload lane + numlanes-1 PAD lanes.
- s_data and s_last are ignored when s_valid=0 or s_ready=0.
- Mid-frame reset: frame is dropped, no EOF is generated, outputs return to reset values.
- Byte count width: clog2(numlanes); never exceeds numlanes-1.

Optional Feature:
- STRIPE_SKIP_EN defined:
  - A word counter (clog2(SKIP_INTERVAL) bits) increments every cycle and saturates at SKIP_INTERVAL-1, setting skip_pending.
  - While skip_pending and state=IDLE, emit SKIP word (all lanes 0x1C, K all ones) instead of idle for one cycle, clear skip_pending, zero the counter.
  - Frame start is deferred by that one cycle: IDLE→SOF transition is blocked during the SKIP cycle.
  - Inside a frame the skip waits until the IDLE cycle after EOF.
  - Counter and flag reset to 0.
- STRIPE_SKIP_EN undefined: no counter logic; IDLE emits only idle words; SKIP_INTERVAL unused.

Test Plan (numlanes=4):
- Reset: assert rst_1G mid-cycle → outputs immediately BCBCBCBC, K=1111, dvalid=0, s_ready=0, busy=0.
- 8-byte frame 01..08, s_valid held high:
  - Sequence: SOF FBBCBCBC K=1111.
  - 01020304 K=0000 dvalid=1 one cycle after byte 04.
  - 05060708 K=0000.
  - EOF FDBCBCBC.
  - Idle; idle words between payload words; busy high SOF..EOF.
- 6-byte frame 11..16 → second word 1516F7F7 K=0011 dvalid=1, next cycle EOF.
- 1-byte frame A5 with s_last → SOF, A5F7F7F7 K=0111, EOF, idle; exactly 3 busy cycles + FILL cycle.
- 4-byte frame with s_valid low every other cycle → word 01020304 appears once, one cycle after the 4th transfer; bubbles emit idle, no data lost.
- Reset asserted after byte 02 of a frame; release, then send 4-byte frame 21..24 → no EOF for the dropped frame; new frame gives SOF, 21222324, EOF. With STRIPE_SKIP_EN and SKIP_INTERVAL=8, link idle → 1C1C1C1C every 8th cycle.
